// File: rtl/edge_detect_pkg.sv
// Shared types for the multi-channel edge detector.
// edge_mode_t selects which filtered transitions count as qualified edges.
package edge_detect_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  function automatic logic mode_qualify(input edge_mode_t m, input logic r, input logic f);
    return (r && (m == EDGE_RISE || m == EDGE_BOTH)) ||
           (f && (m == EDGE_FALL || m == EDGE_BOTH));
  endfunction

endpackage

// File: rtl/edge_detect_ch.sv
// One channel: synchroniser, glitch filter, registered edge pulses and a
// saturating qualified-edge counter.
module edge_detect_ch
  import edge_detect_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 1,
  parameter logic IDLE_VAL    = 1'b1,
  parameter int   CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  edge_mode_t       mode,
  input  logic             cnt_clr,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic             edge_pulse,
  output logic [CNT_W-1:0] edge_cnt,
  output logic             cnt_sat
);

  localparam int             FW      = $clog2(FILTER_LEN) + 1;
  localparam logic [FW-1:0]  FILT_TC = FW'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FW-1:0]          filt_cnt;
  logic                   sync_out;
  logic                   differ;
  logic                   flip;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign differ   = (sync_out != level);
  assign flip     = differ && (filt_cnt == FILT_TC);

  // Resetting the chain to the idle level keeps reset release edge-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{IDLE_VAL}};
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level      <= IDLE_VAL;
      filt_cnt   <= '0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      if (!differ || flip) begin
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
      if (flip) begin
        level <= sync_out;
      end
      rise       <= flip && sync_out;
      fall       <= flip && !sync_out;
      edge_pulse <= mode_qualify(mode, flip && sync_out, flip && !sync_out);
    end
  end

  // Clear takes priority over a coincident pulse; the counter never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      cnt_sat  <= 1'b0;
    end else if (cnt_clr) begin
      edge_cnt <= '0;
      cnt_sat  <= 1'b0;
    end else if (edge_pulse && (edge_cnt != CNT_MAX)) begin
      edge_cnt <= edge_cnt + 1'b1;
      if (edge_cnt == CNT_MAX - 1'b1) begin
        cnt_sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: one edge_detect_ch per line input, with the
// packed mode and counter buses sliced per channel.
module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int                NUM_CH      = 2,
  parameter int                SYNC_STAGES = 2,
  parameter int                FILTER_LEN  = 1,
  parameter logic [NUM_CH-1:0] IDLE_VAL    = {NUM_CH{1'b1}},
  parameter int                CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       din,
  input  logic [2*NUM_CH-1:0]     mode,
  input  logic                    cnt_clr,
  output logic [NUM_CH-1:0]       level,
  output logic [NUM_CH-1:0]       rise,
  output logic [NUM_CH-1:0]       fall,
  output logic [NUM_CH-1:0]       edge_pulse,
  output logic [NUM_CH*CNT_W-1:0] edge_cnt,
  output logic [NUM_CH-1:0]       cnt_sat
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_detect_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .IDLE_VAL    (IDLE_VAL[i]),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .din        (din[i]),
      .mode       (edge_mode_t'(mode[2*i +: 2])),
      .cnt_clr    (cnt_clr),
      .level      (level[i]),
      .rise       (rise[i]),
      .fall       (fall[i]),
      .edge_pulse (edge_pulse[i]),
      .edge_cnt   (edge_cnt[CNT_W*i +: CNT_W]),
      .cnt_sat    (cnt_sat[i])
    );
  end

endmodule
